seg7_scan_driver: RTL and testbench

Parametrised time-multiplexed 7-segment display driver for the game box scoreboard. It scans DIGITS common-anode digits with an internal scan-rate prescaler, so the system clock is used directly and no external clk_1k is needed. Per digit it provides:
- full hex decode,
- decimal points,
- leading-zero blanking,
- blinking.

Data is captured once per frame so a displayed frame never tears.

---
 rtl/seg7_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner: hex decode, dp, leading-zero blanking, blink.
// Optional macro BRIGHTNESS_PWM_EN adds a per-slot brightness window on seg/dp driven by bright[3:0].
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blank_lz,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0]            bright,
`endif
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       fcnt;
  logic                phase;
  logic [4*DIGITS-1:0] data_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [DIGITS-1:0]   blink_sh;
  logic [6:0]          seg_r;
  logic                dp_r;

  logic                tick;
  logic                capture;
  logic [IW-1:0]       idx_nxt;
  logic                phase_nxt;
  logic [3:0]          nib;
  logic                dp_bit;
  logic                blink_bit;
  logic                lz;
  logic                za;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick      = (cnt == CW'(CLK_DIV - 1));
  assign idx_nxt   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
  assign capture   = tick && (idx == IW'(DIGITS - 1));
  assign phase_nxt = (capture && (fcnt == BW'(BLINK_DIV - 1))) ? ~phase : phase;

  // Digit 0 of a new frame decodes the live inputs so it matches what is being captured.
  always_comb begin
    nib       = 4'h0;
    dp_bit    = 1'b0;
    blink_bit = 1'b0;
    lz        = 1'b0;
    za        = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        nib       = data_sh[4*i +: 4];
        dp_bit    = dp_sh[i];
        blink_bit = blink_sh[i];
        if (i != 0) begin
          za = 1'b1;
          for (int j = i; j < DIGITS; j++) begin
            za = za && (data_sh[4*j +: 4] == 4'h0);
          end
          lz = blank_lz && za;
        end
      end
    end
    if (capture) begin
      nib       = disp_data[3:0];
      dp_bit    = dp_in[0];
      blink_bit = blink_mask[0];
      lz        = 1'b0;
    end
    seg_nxt = hex7(nib);
    dp_nxt  = ~dp_bit;
    if (phase_nxt && blink_bit) begin
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
    end else if (lz) begin
      seg_nxt = 7'h7F;
    end
  end

`ifdef BRIGHTNESS_PWM_EN
  logic [3:0] bright_sh;
  int         thr;
  logic       lit;

  always_comb begin
    thr = ((int'(bright_sh) + 1) * CLK_DIV) >>> 4;
    lit = int'(cnt) < thr;
  end

  assign seg = lit ? seg_r : 7'h7F;
  assign dp  = lit ? dp_r  : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bright_sh <= 4'h0;
    end else if (capture) begin
      bright_sh <= bright;
    end
  end
`else
  assign seg = seg_r;
  assign dp  = dp_r;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      idx         <= '0;
      fcnt        <= '0;
      phase       <= 1'b0;
      data_sh     <= '0;
      dp_sh       <= '0;
      blink_sh    <= '0;
      sel         <= DIGITS'(1);
      seg_r       <= 7'h7F;
      dp_r        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + 1'b1;
      frame_start <= capture;
      if (tick) begin
        idx   <= idx_nxt;
        sel   <= {sel[DIGITS-2:0], sel[DIGITS-1]};
        seg_r <= seg_nxt;
        dp_r  <= dp_nxt;
      end
      if (capture) begin
        data_sh  <= disp_data;
        dp_sh    <= dp_in;
        blink_sh <= blink_mask;
        fcnt     <= (fcnt == BW'(BLINK_DIV - 1)) ? '0 : fcnt + 1'b1;
        phase    <= phase_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, CLK_DIV=4, BLINK_DIV=2.
module tb_seg7_scan_driver;

  localparam int DIGITS    = 4;
  localparam int CLK_DIV   = 4;
  localparam int BLINK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] disp_data = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic        blank_lz = 1'b0;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]  bright = 4'hF;
`endif
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  sel;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] fr_seg [4];
  logic       fr_dp  [4];

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS   (DIGITS),
    .CLK_DIV  (CLK_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_data  (disp_data),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
`ifdef BRIGHTNESS_PWM_EN
    .bright     (bright),
`endif
    .seg        (seg),
    .dp         (dp),
    .sel        (sel),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step_to_sel(input logic [3:0] target);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sel !== target && k < 40);
    if (sel !== target) check("sel_timeout", {28'h0, sel}, {28'h0, target});
  endtask

  task automatic wait_frame();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_start !== 1'b1 && k < 40);
    if (frame_start !== 1'b1) check("frame_timeout", {31'h0, frame_start}, 32'h1);
  endtask

  task automatic read_frame();
    wait_frame();
    fr_seg[0] = seg;
    fr_dp[0]  = dp;
    for (int i = 1; i < 4; i++) begin
      step_to_sel(4'(1 << i));
      fr_seg[i] = seg;
      fr_dp[i]  = dp;
    end
  endtask

  logic [3:0] sel_seq [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
  logic [6:0] seg_seq [4] = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b0011001};
  logic       blink_off [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       dp_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int pulses;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_sel", {28'h0, sel}, 32'h1);
    check("rst_seg", {25'h0, seg}, 32'h7F);
    check("rst_dp", {31'h0, dp}, 32'h1);
    check("rst_fs", {31'h0, frame_start}, 32'h0);

    // scan and capture
    rst = 1'b1;
    disp_data = 16'h1234;
    repeat (3) @(negedge clk);
    check("pre_tick_sel", {28'h0, sel}, 32'h1);
    check("pre_tick_seg", {25'h0, seg}, 32'h7F);
    @(negedge clk);
    check("first_tick_sel", {28'h0, sel}, 32'h2);
    check("first_tick_seg", {25'h0, seg}, 32'h40);
    wait_frame();
    check("f0_sel", {28'h0, sel}, 32'h1);
    check("f0_seg", {25'h0, seg}, 32'h19);
    check("f0_dp", {31'h0, dp}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      repeat (CLK_DIV) @(negedge clk);
      check($sformatf("scan_sel%0d", k), {28'h0, sel}, {28'h0, sel_seq[k]});
      check($sformatf("scan_seg%0d", k), {25'h0, seg}, {25'h0, seg_seq[k]});
    end
    check("fs_on_wrap", {31'h0, frame_start}, 32'h1);
    pulses = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (frame_start === 1'b1) pulses++;
    end
    check("fs_per_16", pulses, 32'd2);

    // hex decode
    disp_data = 16'hABCD;
    read_frame();
    check("hex_d", {25'h0, fr_seg[0]}, 32'h21);
    check("hex_C", {25'h0, fr_seg[1]}, 32'h46);
    check("hex_b", {25'h0, fr_seg[2]}, 32'h03);
    check("hex_A", {25'h0, fr_seg[3]}, 32'h08);

    // leading-zero blanking
    disp_data = 16'h0050;
    blank_lz = 1'b1;
    read_frame();
    check("lz_d0", {25'h0, fr_seg[0]}, 32'h40);
    check("lz_d1", {25'h0, fr_seg[1]}, 32'h12);
    check("lz_d2", {25'h0, fr_seg[2]}, 32'h7F);
    check("lz_d3", {25'h0, fr_seg[3]}, 32'h7F);
    disp_data = 16'h0000;
    read_frame();
    check("lz0_d0", {25'h0, fr_seg[0]}, 32'h40);
    check("lz0_d1", {25'h0, fr_seg[1]}, 32'h7F);
    check("lz0_d2", {25'h0, fr_seg[2]}, 32'h7F);
    check("lz0_d3", {25'h0, fr_seg[3]}, 32'h7F);

    // frame coherence
    blank_lz = 1'b0;
    disp_data = 16'h1111;
    read_frame();
    check("coh_pre_d0", {25'h0, fr_seg[0]}, 32'h79);
    wait_frame();
    step_to_sel(4'h2);
    disp_data = 16'h2222;
    check("coh_mid_d1", {25'h0, seg}, 32'h79);
    step_to_sel(4'h4);
    check("coh_mid_d2", {25'h0, seg}, 32'h79);
    step_to_sel(4'h8);
    check("coh_mid_d3", {25'h0, seg}, 32'h79);
    read_frame();
    for (int i = 0; i < 4; i++) check($sformatf("coh_new_d%0d", i), {25'h0, fr_seg[i]}, 32'h24);

    // reset mid-scan
    step_to_sel(4'h4);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_sel", {28'h0, sel}, 32'h1);
    check("mrst_seg", {25'h0, seg}, 32'h7F);
    check("mrst_dp", {31'h0, dp}, 32'h1);
    check("mrst_fs", {31'h0, frame_start}, 32'h0);
    rst = 1'b1;
    disp_data = 16'h1234;
    blink_mask = 4'b0001;
    dp_in = 4'b0010;
    repeat (CLK_DIV - 1) @(negedge clk);
    check("mrst_hold_sel", {28'h0, sel}, 32'h1);
    @(negedge clk);
    check("mrst_resume_sel", {28'h0, sel}, 32'h2);

    // blink and dp, starting from freshly reset blink state
    for (int f = 0; f < 6; f++) begin
      read_frame();
      check($sformatf("blink_f%0d_d0", f), {25'h0, fr_seg[0]},
            blink_off[f] ? 32'h7F : 32'h19);
      check($sformatf("blink_f%0d_d1", f), {25'h0, fr_seg[1]}, 32'h30);
      for (int i = 0; i < 4; i++)
        check($sformatf("dp_f%0d_d%0d", f, i), {31'h0, fr_dp[i]}, {31'h0, dp_exp[i]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
